// File: rtl/pc_unit.sv
// pc_unit: program counter for the RV32IM fetch stage.
// Holds the current fetch address and steps it by 4 each cycle. Supports
// branch/jump redirect, stall, trap redirect and restart. Bad jump targets
// (misaligned or outside instruction memory) park the unit in FAULT. Reaching
// the last word of instruction memory parks it in DONE.
//
// Ports:
//   ip_clk               rising-edge clock
//   ip_rst               asynchronous active-high reset
//   ip_target_addr       jump/branch target address
//   ip_jump_branch_ctrl  redirect PC to ip_target_addr
//   ip_stall_ctrl        hold PC
//   ip_trap_ctrl         redirect PC to TRAP_VEC
//   ip_restart_ctrl      return to RESET_ADDR and RUN from any state
//   op_pc                current PC (registered)
//   op_pc_plus4          op_pc + 4, modulo 2^XLEN
//   op_pc_valid          high in RUN
//   op_done_execute_ctrl high in DONE
//   op_misalign_fault    high in FAULT
//   op_fault_addr        offending target captured on fault entry
module pc_unit #(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN:0]    IMEM_BYTES = (XLEN+1)'(16384),
  parameter logic [XLEN-1:0]  RESET_ADDR = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC   = XLEN'(32'h0000_0100)
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic [XLEN-1:0] ip_target_addr,
  input  logic            ip_jump_branch_ctrl,
  input  logic            ip_stall_ctrl,
  input  logic            ip_trap_ctrl,
  input  logic            ip_restart_ctrl,
  output logic [XLEN-1:0] op_pc,
  output logic [XLEN-1:0] op_pc_plus4,
  output logic            op_pc_valid,
  output logic            op_done_execute_ctrl,
  output logic            op_misalign_fault,
  output logic [XLEN-1:0] op_fault_addr
);

  // Memory size is kept one bit wider than XLEN so a full 2^XLEN memory is
  // representable and the range check below stays exact.
  localparam logic [XLEN:0]   LP_LAST_WIDE = IMEM_BYTES - (XLEN+1)'(4);
  localparam logic [XLEN-1:0] LP_LAST_ADDR = LP_LAST_WIDE[XLEN-1:0];

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_fault_addr;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_fault_addr_nxt;
  logic            w_target_bad;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4   = r_pc + XLEN'(4);
  assign w_target_bad = (ip_target_addr[1:0] != 2'b00) ||
                        ({1'b0, ip_target_addr} >= IMEM_BYTES);

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_ADDR;
      r_fault_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fault_addr <= w_fault_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fault_addr_nxt = r_fault_addr;
    if (ip_restart_ctrl) begin
      w_state_nxt      = ST_RUN;
      w_pc_nxt         = RESET_ADDR;
      w_fault_addr_nxt = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (ip_trap_ctrl) begin
            w_pc_nxt = TRAP_VEC;
          end else if (ip_jump_branch_ctrl && w_target_bad) begin
            w_state_nxt      = ST_FAULT;
            w_fault_addr_nxt = ip_target_addr;
          end else if (ip_jump_branch_ctrl) begin
            w_pc_nxt = ip_target_addr;
          end else if (ip_stall_ctrl) begin
            w_pc_nxt = r_pc;
          end else if (r_pc == LP_LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
        ST_DONE:  w_pc_nxt = r_pc;
        ST_FAULT: w_pc_nxt = r_pc;
        default: begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_ADDR;
        end
      endcase
    end
  end

  assign op_pc                = r_pc;
  assign op_pc_plus4          = w_pc_plus4;
  assign op_pc_valid          = (r_state == ST_RUN);
  assign op_done_execute_ctrl = (r_state == ST_DONE);
  assign op_misalign_fault    = (r_state == ST_FAULT);
  assign op_fault_addr        = r_fault_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit: default 16 KiB instance plus a 64-byte
// instance for the small-memory boundary.
module tb_pc_unit;

  logic        clk;
  logic        rst, rst2;
  logic [31:0] tgt, tgt2;
  logic        jmp, stall, trap, rstrt;
  logic        jmp2, stall2, trap2, rstrt2;
  logic [31:0] pc, pc4, faddr, pc_b, pc4_b, faddr_b;
  logic        valid, done, fault, valid_b, done_b, fault_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pc_unit u_dut (
    .ip_clk(clk), .ip_rst(rst), .ip_target_addr(tgt),
    .ip_jump_branch_ctrl(jmp), .ip_stall_ctrl(stall), .ip_trap_ctrl(trap),
    .ip_restart_ctrl(rstrt), .op_pc(pc), .op_pc_plus4(pc4),
    .op_pc_valid(valid), .op_done_execute_ctrl(done),
    .op_misalign_fault(fault), .op_fault_addr(faddr)
  );

  pc_unit #(.XLEN(32), .IMEM_BYTES(33'd64)) u_dut64 (
    .ip_clk(clk), .ip_rst(rst2), .ip_target_addr(tgt2),
    .ip_jump_branch_ctrl(jmp2), .ip_stall_ctrl(stall2), .ip_trap_ctrl(trap2),
    .ip_restart_ctrl(rstrt2), .op_pc(pc_b), .op_pc_plus4(pc4_b),
    .op_pc_valid(valid_b), .op_done_execute_ctrl(done_b),
    .op_misalign_fault(fault_b), .op_fault_addr(faddr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jmp = 0; stall = 0; trap = 0; rstrt = 0; tgt = '0;
  endtask

  task automatic exp_pc(input string tag, input logic [31:0] e);
    chk(tag, pc, e);
    chk({tag, "_p4"}, pc4, e + 32'd4);
  endtask

  initial begin
    idle();
    rst = 1; rst2 = 1;
    jmp2 = 0; stall2 = 0; trap2 = 0; rstrt2 = 0; tgt2 = '0;
    #3;
    exp_pc("rst_pc", 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_faddr", faddr, 32'd0);
    @(negedge clk); rst = 0;

    // Free run
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc("run_pc", 32'(4 * i));
      chk("run_valid", {31'd0, valid}, 32'd1);
    end

    // Jump, stall, jump overriding stall
    jmp = 1; tgt = 32'h8; step(); exp_pc("jmp8", 32'h8);
    jmp = 0; stall = 1;
    for (int i = 0; i < 3; i++) begin step(); exp_pc("stall", 32'h8); end
    jmp = 1; tgt = 32'h40; step(); exp_pc("jmp_over_stall", 32'h40);
    idle();

    // Trap priority
    jmp = 1; tgt = 32'h8; step(); exp_pc("jmp8b", 32'h8);
    trap = 1; jmp = 1; tgt = 32'h20; step(); exp_pc("trap_jmp", 32'h100);
    idle(); step(); exp_pc("after_trap", 32'h104);
    trap = 1; stall = 1; step(); exp_pc("trap_stall", 32'h100);
    idle();

    // Run to last address
    jmp = 1; tgt = 32'h3FF8; step(); exp_pc("jmp_3ff8", 32'h3FF8);
    idle(); step(); exp_pc("pc_3ffc", 32'h3FFC);
    chk("pre_done", {31'd0, done}, 32'd0);
    step(); exp_pc("done_pc", 32'h3FFC);
    chk("done", {31'd0, done}, 32'd1);
    chk("done_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    exp_pc("done_hold", 32'h3FFC);
    jmp = 1; tgt = 32'h0; step(); exp_pc("done_ign_jmp", 32'h3FFC);
    jmp = 0; trap = 1; step(); exp_pc("done_ign_trap", 32'h3FFC);
    chk("done_still", {31'd0, done}, 32'd1);
    idle();

    // Asynchronous reset mid-cycle while in DONE
    #2; rst = 1; #1;
    exp_pc("arst_pc", 32'h0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd1);
    @(negedge clk); rst = 0;

    // Jump to last address is legal; restart exits DONE
    jmp = 1; tgt = 32'h3FFC; step(); exp_pc("jmp_last", 32'h3FFC);
    chk("jmp_last_fault", {31'd0, fault}, 32'd0);
    idle(); step();
    chk("done2", {31'd0, done}, 32'd1);
    rstrt = 1; step(); exp_pc("restart_pc", 32'h0);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_valid", {31'd0, valid}, 32'd1);
    idle();

    // Misaligned target
    step(); exp_pc("pre_mis", 32'h4);
    jmp = 1; tgt = 32'h6; step();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_faddr", faddr, 32'h6);
    exp_pc("mis_pc", 32'h4);
    chk("mis_valid", {31'd0, valid}, 32'd0);
    tgt = 32'h0; trap = 1; step();
    exp_pc("fault_ign", 32'h4);
    chk("fault_faddr_stable", faddr, 32'h6);
    idle(); rstrt = 1; step();
    chk("rs_fault", {31'd0, fault}, 32'd0);
    chk("rs_faddr", faddr, 32'h0);
    exp_pc("rs_pc", 32'h0);
    idle();

    // Out-of-range target
    step();
    jmp = 1; tgt = 32'h4000; step();
    chk("oor_fault", {31'd0, fault}, 32'd1);
    chk("oor_faddr", faddr, 32'h4000);
    exp_pc("oor_pc", 32'h4);
    idle(); rstrt = 1; step();
    chk("rs2_fault", {31'd0, fault}, 32'd0);
    chk("rs2_faddr", faddr, 32'h0);
    idle();

    // Small 64-byte instance
    @(negedge clk); rst2 = 0;
    jmp2 = 1; tgt2 = 32'h38; step(); chk("s_jmp", pc_b, 32'h38);
    jmp2 = 0; step(); chk("s_pc3c", pc_b, 32'h3C);
    chk("s_pc4", pc4_b, 32'h40);
    chk("s_predone", {31'd0, done_b}, 32'd0);
    step(); chk("s_done_pc", pc_b, 32'h3C);
    chk("s_done", {31'd0, done_b}, 32'd1);
    #2; rst2 = 1; #1;
    chk("s_arst_pc", pc_b, 32'h0);
    chk("s_arst_done", {31'd0, done_b}, 32'd0);
    @(negedge clk); rst2 = 0;
    jmp2 = 1; tgt2 = 32'h40; step();
    chk("s_oor_fault", {31'd0, fault_b}, 32'd1);
    chk("s_oor_faddr", faddr_b, 32'h40);
    chk("s_oor_pc", pc_b, 32'h0);
    jmp2 = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the RV32IM core fetch stage; generalises the current PC in address width, instruction-memory size, reset address and trap vector.
- Adds trap redirection, misaligned/out-of-range target fault detection, restart from the halted state, and a registered RUN/DONE/FAULT state machine.
- Drives the instruction-memory address and PC+4 to the fetch/decode stages; consumes redirect/stall controls from hazard and execute logic.

Parameters:
- XLEN, 32, address/PC width in bits.
- IMEM_BYTES, 16384, instruction memory size in bytes; power of two, >= 8, <= 2^XLEN.
- RESET_ADDR, 32'h0000_0000, PC value after reset or restart; word-aligned, < IMEM_BYTES.
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap; word-aligned, < IMEM_BYTES.

Ports:
- ip_clk  in  1  clock, rising-edge.
- ip_rst  in  1  asynchronous reset, active-high.
- ip_target_addr  in  XLEN  jump/branch target address.
- ip_jump_branch_ctrl  in  1  redirect PC to ip_target_addr.
- ip_stall_ctrl  in  1  hold PC.
- ip_trap_ctrl  in  1  redirect PC to TRAP_VEC.
- ip_restart_ctrl  in  1  return to RESET_ADDR and RUN from any state.
- op_pc  out  XLEN  current PC (registered).
- op_pc_plus4  out  XLEN  op_pc + 4, combinational, modulo 2^XLEN.
- op_pc_valid  out  1  high when state is RUN.
- op_done_execute_ctrl  out  1  high in DONE (last instruction reached).
- op_misalign_fault  out  1  high in FAULT.
- op_fault_addr  out  XLEN  offending target captured on fault entry.

Behaviour:
- LAST_ADDR = IMEM_BYTES - 4.
- Reset (async, any time, including mid-operation):
  - op_pc = RESET_ADDR; state = RUN.
  - op_done_execute_ctrl = 0, op_misalign_fault = 0, op_fault_addr = 0, op_pc_valid = 1, op_pc_plus4 = RESET_ADDR + 4.
- State flags are decoded from registered state; the state change is visible the cycle after the causing edge.
- Restart: in any state, ip_restart_ctrl = 1 at an edge gives op_pc <= RESET_ADDR, state <= RUN, op_fault_addr <= 0. Restart has highest priority after reset.
- RUN, per rising edge, first match wins:
  1. ip_trap_ctrl: op_pc <= TRAP_VEC.
  2. ip_jump_branch_ctrl with a bad target:
     - Bad means ip_target_addr[1:0] != 0, or ip_target_addr >= IMEM_BYTES (unsigned).
     - state <= FAULT; op_fault_addr <= ip_target_addr; op_pc holds.
  3. ip_jump_branch_ctrl with a good target: op_pc <= ip_target_addr. The redirect overrides a simultaneous stall.
  4. ip_stall_ctrl: op_pc holds.
  5. op_pc == LAST_ADDR: state <= DONE; op_pc holds at LAST_ADDR.
  6. Otherwise op_pc <= op_pc + 4.
- DONE: op_pc holds. Trap, jump, and stall are ignored. Only restart or reset exits.
- FAULT: op_pc holds. op_fault_addr is stable. All controls except restart are ignored.
- A jump to LAST_ADDR is legal. The next non-stalled, non-redirected edge enters DONE.
- op_pc never exceeds LAST_ADDR in RUN, so no wrap-around occurs. op_pc_plus4 wraps modulo 2^XLEN if LAST_ADDR + 4 = 2^XLEN.
- Stall held indefinitely holds op_pc indefinitely. No internal timeout.

Test Plan:
- Reset then free-run, 4 edges with controls low -> op_pc 0x0, 0x4, 0x8, 0xC, 0x10; op_pc_valid = 1; op_pc_plus4 = op_pc + 4.
- From op_pc = 0x10, jump = 1 with target 0x8 for one edge -> op_pc = 0x8. Then stall = 1 for 3 edges -> op_pc stays 0x8. Stall and jump both high with target 0x40 -> op_pc = 0x40.
- Jump to 0x3FF8, then 6 idle edges -> op_pc 0x3FF8, 0x3FFC, then done = 1 and op_pc holds 0x3FFC. During DONE, a jump to 0x0 and a trap are ignored. Restart -> op_pc = 0x0, done = 0.
- Jump to 0x0000_0006 -> op_misalign_fault = 1, op_fault_addr = 0x6, op_pc unchanged, op_pc_valid = 0. Repeat with target 0x4000 -> fault, op_fault_addr = 0x4000. Restart clears fault and fault address.
- Trap together with jump (target 0x20) from op_pc = 0x8 -> op_pc = 0x100. Trap together with stall -> op_pc = 0x100.
- Assert ip_rst asynchronously mid-cycle while op_pc = 0x3FFC in DONE -> op_pc = 0x0 and done = 0 immediately, without waiting for a clock edge. Repeat with parameters XLEN = 32, IMEM_BYTES = 64 -> DONE at op_pc = 0x3C.
